// File: rtl/y_motion_pkg.sv
// y_motion_pkg: shared constants for the running-man vertical motion block.
// Move codes, key bit positions, the two-state move FSM type and a width
// helper for the signed y + v sum.
// Optional build macro used by the block: Y_MOTION_KEY_EDGE_EN.
package y_motion_pkg;

    localparam logic [1:0] MV_IDLE = 2'b00;
    localparam logic [1:0] MV_BJ   = 2'b01;
    localparam logic [1:0] MV_SJ   = 2'b10;
    localparam logic [1:0] MV_DROP = 2'b11;

    localparam int KEY_BJ   = 0;
    localparam int KEY_SJ   = 1;
    localparam int KEY_DROP = 2;
    localparam int KEY_N    = 3;

    typedef enum logic {
        ST_IDLE,
        ST_MOVE
    } state_t;

    // Width of the signed y + v sum: one bit of headroom plus a sign bit.
    function automatic int ext_w(input int y_w);
        return y_w + 2;
    endfunction

endpackage

// File: rtl/y_key_arbiter.sv
// y_key_arbiter: picks which move to launch from the active-low keys.
// Priority key0 > key1 > key2; a key blocked by its y guard falls through to
// the next pressed key. Produces a one-hot request, launch velocity and the
// absolute landing target.
// Y_MOTION_KEY_EDGE_EN: when defined, a key counts only on its press edge.
module y_key_arbiter
    import y_motion_pkg::*;
#(
    parameter int Y_W       = 7,
    parameter int V_W       = 5,
    parameter int LEVEL_H   = 40,
    parameter int BJ_V0     = 9,
    parameter int SJ_V0     = 7,
    parameter int DROP_V0   = 1,
    parameter int TOP_GUARD = 40,
    parameter int BOT_GUARD = 80
)
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  idle,
    input  logic [KEY_N-1:0]      key_n,
    input  logic [Y_W-1:0]        y,
    output logic [KEY_N-1:0]      req,
    output logic signed [V_W-1:0] launch_v,
    output logic [Y_W-1:0]        target
);

    localparam logic [Y_W-1:0]        TOP_G   = Y_W'(TOP_GUARD);
    localparam logic [Y_W-1:0]        BOT_G   = Y_W'(BOT_GUARD);
    localparam logic [Y_W-1:0]        LEVEL_Y = Y_W'(LEVEL_H);
    localparam logic signed [V_W-1:0] BJ_LV   = V_W'(-BJ_V0);
    localparam logic signed [V_W-1:0] SJ_LV   = V_W'(-SJ_V0);
    localparam logic signed [V_W-1:0] DROP_LV = V_W'(DROP_V0);

    logic [KEY_N-1:0] pressed;

`ifdef Y_MOTION_KEY_EDGE_EN
    logic [KEY_N-1:0] key_hist;

    // Remember last clk's key levels so only a released-to-pressed change counts.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_hist <= 3'b111;
        end else begin
            key_hist <= key_n;
        end
    end

    assign pressed = key_hist & ~key_n;
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk & resetn;
    assign pressed        = ~key_n;
`endif

    // Priority select with guard fall-through; nothing is requested while busy or disabled.
    always_comb begin
        req      = '0;
        launch_v = '0;
        target   = '0;
        if (enable && idle) begin
            if (pressed[KEY_BJ] && (y > TOP_G)) begin
                req[KEY_BJ] = 1'b1;
                launch_v    = BJ_LV;
                target      = y - LEVEL_Y;
            end else if (pressed[KEY_SJ]) begin
                req[KEY_SJ] = 1'b1;
                launch_v    = SJ_LV;
                target      = y;
            end else if (pressed[KEY_DROP] && (y < BOT_G)) begin
                req[KEY_DROP] = 1'b1;
                launch_v      = DROP_LV;
                target        = y + LEVEL_Y;
            end
        end
    end

endmodule

// File: rtl/y_motion_ctrl.sv
// y_motion_ctrl: vertical motion of the running-man sprite.
// A signed velocity register plus constant gravity drives y once per tick;
// landing snaps y to the move's target while falling.
// Y_MOTION_KEY_EDGE_EN: when defined, launches need a fresh key press edge.
module y_motion_ctrl
    import y_motion_pkg::*;
#(
    parameter int Y_W       = 7,
    parameter int V_W       = 5,
    parameter int Y_RESET   = 108,
    parameter int LEVEL_H   = 40,
    parameter int BJ_V0     = 9,
    parameter int SJ_V0     = 7,
    parameter int DROP_V0   = 1,
    parameter int GRAV      = 1,
    parameter int V_MAX     = 9,
    parameter int TOP_GUARD = 40,
    parameter int BOT_GUARD = 80
)
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic           enable,
    input  logic [2:0]     key_n,
    output logic [Y_W-1:0] y,
    output logic           busy,
    output logic [1:0]     move,
    output logic           land
);

    localparam int                    NXT_W   = ext_w(Y_W);
    localparam logic signed [V_W:0]   V_MAX_X = (V_W+1)'(V_MAX);
    localparam logic signed [V_W:0]   GRAV_X  = (V_W+1)'(GRAV);

    state_t                  state, state_nxt;
    logic signed [V_W-1:0]   v;
    logic [Y_W-1:0]          target;

    logic [KEY_N-1:0]        req;
    logic signed [V_W-1:0]   launch_v;
    logic [Y_W-1:0]          launch_tgt;
    logic                    launch;
    logic [1:0]              launch_move;

    logic signed [NXT_W-1:0] nxt;
    logic signed [V_W:0]     v_inc;
    logic signed [V_W-1:0]   v_next;
    logic                    falling;
    logic                    hit;

    y_key_arbiter #(
        .Y_W      (Y_W),
        .V_W      (V_W),
        .LEVEL_H  (LEVEL_H),
        .BJ_V0    (BJ_V0),
        .SJ_V0    (SJ_V0),
        .DROP_V0  (DROP_V0),
        .TOP_GUARD(TOP_GUARD),
        .BOT_GUARD(BOT_GUARD)
    ) u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (enable),
        .idle    (state == ST_IDLE),
        .key_n   (key_n),
        .y       (y),
        .req     (req),
        .launch_v(launch_v),
        .target  (launch_tgt)
    );

    assign launch      = |req;
    assign launch_move = req[KEY_BJ] ? MV_BJ : (req[KEY_SJ] ? MV_SJ : MV_DROP);

    assign nxt     = $signed({2'b00, y}) + $signed({{(NXT_W-V_W){v[V_W-1]}}, v});
    assign falling = !v[V_W-1] && (v != '0);
    assign hit     = falling && (nxt >= $signed({2'b00, target}));
    assign v_inc   = $signed({v[V_W-1], v}) + GRAV_X;
    assign v_next  = (v_inc > V_MAX_X) ? V_MAX_X[V_W-1:0] : v_inc[V_W-1:0];

    // Move FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Launch from idle on any edge; return to idle on the landing tick.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                busy = 1'b1;
                if (tick && hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Velocity, target and y datapath; acceptance loads launch values without moving y.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            y      <= Y_W'(Y_RESET);
            v      <= '0;
            target <= '0;
            move   <= MV_IDLE;
            land   <= 1'b0;
        end else begin
            land <= 1'b0;
            if (state == ST_IDLE) begin
                if (launch) begin
                    v      <= launch_v;
                    target <= launch_tgt;
                    move   <= launch_move;
                end
            end else if (tick) begin
                if (hit) begin
                    y    <= target;
                    v    <= '0;
                    move <= MV_IDLE;
                    land <= 1'b1;
                end else begin
                    if (nxt[NXT_W-1]) begin
                        y <= '0;
                    end else if (|nxt[NXT_W-2:Y_W]) begin
                        y <= '1;
                    end else begin
                        y <= nxt[Y_W-1:0];
                    end
                    v <= v_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_y_motion_ctrl.sv
// tb_y_motion_ctrl: directed self-checking bench for y_motion_ctrl.
// Inputs change on the falling edge; outputs are checked on the falling edge
// after the rising edge that acted on them.
// Y_MOTION_KEY_EDGE_EN selects the expected behaviour of the held-key scenario.
module tb_y_motion_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       tick;
    logic       enable;
    logic [2:0] key_n;
    logic [6:0] y;
    logic       busy;
    logic [1:0] move;
    logic       land;

    int checks = 0;
    int passes = 0;

    y_motion_ctrl dut (
        .clk   (clk),
        .resetn(resetn),
        .tick  (tick),
        .enable(enable),
        .key_n (key_n),
        .y     (y),
        .busy  (busy),
        .move  (move),
        .land  (land)
    );

    always #5 clk = ~clk;

    // Hold keys (and optionally tick) for exactly one rising edge.
    task automatic press(input logic [2:0] kn, input logic tk);
        @(negedge clk);
        key_n = kn;
        tick  = tk;
        @(negedge clk);
        key_n = 3'b111;
        tick  = 1'b0;
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (y !== 7'd108) $display("[TB] FAIL reset_y: got %0d expected 108", y); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
        checks++; if (move !== 2'b00) $display("[TB] FAIL reset_move: got %0b expected 00", move); else passes++;
        checks++; if (land !== 1'b0) $display("[TB] FAIL reset_land: got %0b expected 0", land); else passes++;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_sj_jump();
        int exp_y[15] = '{101, 95, 90, 86, 83, 81, 80, 80, 81, 83, 86, 90, 95, 101, 108};
        press(3'b101, 1'b1);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL sj_busy: got %0b expected 1", busy); else passes++;
        checks++; if (move !== 2'b10) $display("[TB] FAIL sj_move: got %0b expected 10", move); else passes++;
        checks++; if (y !== 7'd108) $display("[TB] FAIL sj_tick_at_accept: got %0d expected 108", y); else passes++;
        for (int i = 0; i < 15; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_y[i])) $display("[TB] FAIL sj_y[%0d]: got %0d expected %0d", i, y, exp_y[i]); else passes++;
            checks++; if (land !== (i == 14)) $display("[TB] FAIL sj_land[%0d]: got %0b expected %0b", i, land, (i == 14)); else passes++;
        end
        checks++; if (busy !== 1'b0) $display("[TB] FAIL sj_busy_end: got %0b expected 0", busy); else passes++;
        checks++; if (move !== 2'b00) $display("[TB] FAIL sj_move_end: got %0b expected 00", move); else passes++;
        @(negedge clk);
        checks++; if (land !== 1'b0) $display("[TB] FAIL sj_land_pulse: got %0b expected 0", land); else passes++;
    endtask

    task automatic test_bj_jump();
        int exp_a[13] = '{99, 91, 84, 78, 73, 69, 66, 64, 63, 63, 64, 66, 68};
        int exp_b[13] = '{59, 51, 44, 38, 33, 29, 26, 24, 23, 23, 24, 26, 28};
        press(3'b110, 1'b0);
        checks++; if (move !== 2'b01) $display("[TB] FAIL bj_move: got %0b expected 01", move); else passes++;
        for (int i = 0; i < 13; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_a[i])) $display("[TB] FAIL bj_a_y[%0d]: got %0d expected %0d", i, y, exp_a[i]); else passes++;
        end
        checks++; if (land !== 1'b1) $display("[TB] FAIL bj_a_land: got %0b expected 1", land); else passes++;
        press(3'b110, 1'b0);
        for (int i = 0; i < 13; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_b[i])) $display("[TB] FAIL bj_b_y[%0d]: got %0d expected %0d", i, y, exp_b[i]); else passes++;
        end
        press(3'b110, 1'b0);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL bj_guard_busy: got %0b expected 0", busy); else passes++;
    endtask

    task automatic test_fall_through();
        int exp_y[9] = '{29, 31, 34, 38, 43, 49, 56, 64, 68};
        press(3'b010, 1'b0);
        checks++; if (move !== 2'b11) $display("[TB] FAIL ft_move: got %0b expected 11", move); else passes++;
        for (int i = 0; i < 9; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_y[i])) $display("[TB] FAIL ft_y[%0d]: got %0d expected %0d", i, y, exp_y[i]); else passes++;
        end
    endtask

    task automatic test_drop();
        int exp_y[9] = '{69, 71, 74, 78, 83, 89, 96, 104, 108};
        press(3'b011, 1'b0);
        checks++; if (move !== 2'b11) $display("[TB] FAIL drop_move: got %0b expected 11", move); else passes++;
        for (int i = 0; i < 9; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_y[i])) $display("[TB] FAIL drop_y[%0d]: got %0d expected %0d", i, y, exp_y[i]); else passes++;
            checks++; if (land !== (i == 8)) $display("[TB] FAIL drop_land[%0d]: got %0b expected %0b", i, land, (i == 8)); else passes++;
        end
    endtask

    task automatic test_priority();
        press(3'b100, 1'b0);
        checks++; if (move !== 2'b01) $display("[TB] FAIL prio_move: got %0b expected 01", move); else passes++;
        for (int i = 0; i < 13; i++) do_tick();
        checks++; if (y !== 7'd68) $display("[TB] FAIL prio_y: got %0d expected 68", y); else passes++;
        press(3'b011, 1'b0);
        for (int i = 0; i < 9; i++) do_tick();
        checks++; if (y !== 7'd108) $display("[TB] FAIL prio_back_y: got %0d expected 108", y); else passes++;
        press(3'b011, 1'b0);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL drop_guard_busy: got %0b expected 0", busy); else passes++;
    endtask

    task automatic test_enable_busy();
        enable = 1'b0;
        press(3'b101, 1'b0);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL en_block_busy: got %0b expected 0", busy); else passes++;
        enable = 1'b1;
        press(3'b101, 1'b0);
        do_tick();
        do_tick();
        checks++; if (y !== 7'd95) $display("[TB] FAIL en_y2: got %0d expected 95", y); else passes++;
        enable = 1'b0;
        press(3'b110, 1'b0);
        checks++; if (move !== 2'b10) $display("[TB] FAIL busy_ignore_move: got %0b expected 10", move); else passes++;
        for (int i = 0; i < 13; i++) do_tick();
        checks++; if (y !== 7'd108) $display("[TB] FAIL en_finish_y: got %0d expected 108", y); else passes++;
        checks++; if (land !== 1'b1) $display("[TB] FAIL en_finish_land: got %0b expected 1", land); else passes++;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int exp_y[15] = '{101, 95, 90, 86, 83, 81, 80, 80, 81, 83, 86, 90, 95, 101, 108};
        press(3'b101, 1'b0);
        for (int i = 0; i < 3; i++) do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (y !== 7'd86) $display("[TB] FAIL rm_y4: got %0d expected 86", y); else passes++;
        resetn = 1'b0;
        #1;
        checks++; if (y !== 7'd108) $display("[TB] FAIL rm_y: got %0d expected 108", y); else passes++;
        checks++; if (move !== 2'b00) $display("[TB] FAIL rm_move: got %0b expected 00", move); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rm_busy: got %0b expected 0", busy); else passes++;
        @(negedge clk);
        tick   = 1'b0;
        resetn = 1'b1;
        press(3'b101, 1'b0);
        for (int i = 0; i < 15; i++) begin
            do_tick();
            checks++; if (y !== 7'(exp_y[i])) $display("[TB] FAIL rm_y[%0d]: got %0d expected %0d", i, y, exp_y[i]); else passes++;
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        key_n = 3'b101;
        @(negedge clk);
        checks++; if (busy !== 1'b1) $display("[TB] FAIL hold_start: got %0b expected 1", busy); else passes++;
        for (int i = 0; i < 15; i++) do_tick();
        checks++; if (land !== 1'b1) $display("[TB] FAIL hold_land: got %0b expected 1", land); else passes++;
        @(negedge clk);
`ifdef Y_MOTION_KEY_EDGE_EN
        checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_no_relaunch: got %0b expected 0", busy); else passes++;
        for (int i = 0; i < 10; i++) do_tick();
        checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_still_idle: got %0b expected 0", busy); else passes++;
        key_n = 3'b111;
        @(negedge clk);
        key_n = 3'b101;
        @(negedge clk);
        key_n = 3'b111;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL hold_repress: got %0b expected 1", busy); else passes++;
`else
        checks++; if (busy !== 1'b1) $display("[TB] FAIL hold_relaunch: got %0b expected 1", busy); else passes++;
        checks++; if (move !== 2'b10) $display("[TB] FAIL hold_relaunch_move: got %0b expected 10", move); else passes++;
        key_n = 3'b111;
`endif
        for (int i = 0; i < 15; i++) do_tick();
        checks++; if (y !== 7'd108) $display("[TB] FAIL hold_end_y: got %0d expected 108", y); else passes++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_end_busy: got %0b expected 0", busy); else passes++;
    endtask

    initial begin
        resetn = 1'b0;
        tick   = 1'b0;
        enable = 1'b1;
        key_n  = 3'b111;
        test_reset();
        test_sj_jump();
        test_bj_jump();
        test_fall_through();
        test_drop();
        test_priority();
        test_enable_busy();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
